// File: rtl/clock_period_meter_pkg.sv
// Shared types and helpers for the clock period meter and its neighbours.
package clock_pkg;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    STALLED    = 2'd2
  } state_t;

  // All-ones value for a counter of the given width (width <= 63).
  function automatic logic [63:0] cnt_max(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/clock_period_meter_if.sv
// Measurement bus: control/stimulus in, period results out.
interface clock_period_meter_if #(
  parameter int CNT_WIDTH = 24
);
  logic                 en;
  logic                 sig_in;
  logic [CNT_WIDTH-1:0] period;
  logic [CNT_WIDTH-1:0] high_time;
  logic                 valid;
  logic                 stalled;

  // Side that drives the signal under test and consumes the results.
  modport master (
    output en, sig_in,
    input  period, high_time, valid, stalled
  );

  // The meter itself.
  modport slave (
    input  en, sig_in,
    output period, high_time, valid, stalled
  );
endinterface

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input plus rise/fall strobes.
// Latency from async_in to a strobe is SYNC_STAGES+1 clk edges.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift the async input through the synchronizer and keep one delayed copy.
  // NOTE: these flops are reset so a stale level cannot produce a phantom edge
  // right after reset; the first stage may still go metastable, which is why
  // nothing but the next stage ever reads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_out;
    end
  end

  assign rise = sync_out & ~prev_q;
  assign fall = ~sync_out & prev_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow clock/pulse train in clk cycles,
// reporting once per input cycle and flagging a stalled input.
module clock_period_meter
  import clock_pkg::*;
#(
  parameter int CNT_WIDTH   = 24,
  parameter int SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  rst,
  clock_period_meter_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic rise;
  logic fall;

  state_t               state_q,  state_n;
  logic [CNT_WIDTH-1:0] cnt_q,    cnt_n;
  logic [CNT_WIDTH-1:0] hi_lat_q, hi_lat_n;
  logic [CNT_WIDTH-1:0] period_q, period_n;
  logic [CNT_WIDTH-1:0] high_q,   high_n;
  logic                 valid_q,  valid_n;
  logic                 stall_q,  stall_n;
  logic [CNT_WIDTH-1:0] cnt_inc;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.sig_in),
    .rise     (rise),
    .fall     (fall)
  );

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

  // Register all FSM and datapath state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_FIRST;
      cnt_q    <= '0;
      hi_lat_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      hi_lat_q <= hi_lat_n;
      period_q <= period_n;
      high_q   <= high_n;
      valid_q  <= valid_n;
      stall_q  <= stall_n;
    end
  end

  // Next-state and datapath decisions; a rise always takes priority over a stall.
  always_comb begin
    // NOTE: every target gets a hold/default value first so that no path through
    // the case below leaves a signal unassigned and infers a latch.
    state_n  = state_q;
    cnt_n    = cnt_q;
    hi_lat_n = hi_lat_q;
    period_n = period_q;
    high_n   = high_q;
    valid_n  = 1'b0;
    stall_n  = stall_q;

    if (!bus.en) begin
      state_n = WAIT_FIRST;
      stall_n = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_FIRST: begin
          if (rise) begin
            cnt_n    = CNT_ONE;
            hi_lat_n = '0;
            state_n  = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_n = cnt_q;
            high_n   = hi_lat_q;
            valid_n  = 1'b1;
            cnt_n    = CNT_ONE;
            hi_lat_n = '0;
          end else begin
            cnt_n = cnt_inc;
            if (fall) hi_lat_n = cnt_q;
            if (cnt_q == CNT_MAX) begin
              stall_n = 1'b1;
              state_n = STALLED;
            end
          end
        end
        STALLED: begin
          if (rise) begin
            stall_n  = 1'b0;
            cnt_n    = CNT_ONE;
            hi_lat_n = '0;
            state_n  = MEASURE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: state_n = WAIT_FIRST;
      endcase
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_q;
  assign bus.valid     = valid_q;
  assign bus.stalled   = stall_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: steady waves, minimum period, stall
// on a narrow counter, enable drop, reset mid-run and an async-phase input.
`timescale 1ns/1ps
module tb_clock_period_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec      = 0;
  int n_bad      = 0;
  int valid_cnt  = 0;
  int valid8_cnt = 0;
  int exp_per    = 0;
  int exp_high   = 0;

  always #5 clk = ~clk;

  clock_period_meter_if #(.CNT_WIDTH(24)) bus  ();
  clock_period_meter_if #(.CNT_WIDTH(8))  bus8 ();

  clock_period_meter #(.CNT_WIDTH(24), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  clock_period_meter #(.CNT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Every valid on the wide meter must carry the period/high of the current scenario.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      valid_cnt++;
      check("valid_period", 32'(bus.period), exp_per);
      check("valid_high", 32'(bus.high_time), exp_high);
    end
    if (bus8.valid === 1'b1) valid8_cnt++;
  end

  // Synchronous square wave on the wide meter: n rises, each 'hi' clocks high.
  task automatic run_wave(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 bus.sig_in = 1'b1;
      repeat (hi) @(posedge clk);
      #1 bus.sig_in = 1'b0;
      repeat (per - hi - 1) @(posedge clk);
    end
  endtask

  // Drop enable briefly so the next scenario starts from WAIT_FIRST.
  task automatic restart(input int per, input int hi);
    @(posedge clk); #1 bus.en = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.en = 1'b1;
    exp_per   = per;
    exp_high  = hi;
    valid_cnt = 0;
  endtask

  initial begin
    int off;
    bus.en = 1'b0;  bus.sig_in = 1'b0;
    bus8.en = 1'b0; bus8.sig_in = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_period", 32'(bus.period), 0);
    check("rst_high", 32'(bus.high_time), 0);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_stalled", 32'(bus.stalled), 0);
    check("rst_stalled8", 32'(bus8.stalled), 0);

    // 1: period 10, high 3 -> 6 rises give 5 valids
    restart(10, 3);
    run_wave(10, 3, 6);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("s1_valids", valid_cnt, 5);
    check("s1_period", 32'(bus.period), 10);
    check("s1_high", 32'(bus.high_time), 3);

    // 2: toggling every clk -> period 2, high 1
    restart(2, 1);
    run_wave(2, 1, 8);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("s2_valids", valid_cnt, 7);
    check("s2_period", 32'(bus.period), 2);
    check("s2_high", 32'(bus.high_time), 1);

    // 4: en dropped for 5 clks across a rise; outputs hold, valid suppressed
    restart(10, 3);
    run_wave(10, 3, 3);
    @(posedge clk); #1 bus.sig_in = 1'b1; bus.en = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.sig_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.en = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("s4_valids_hold", valid_cnt, 2);
    check("s4_period_hold", 32'(bus.period), 10);
    check("s4_high_hold", 32'(bus.high_time), 3);
    check("s4_stalled", 32'(bus.stalled), 0);
    run_wave(10, 3, 3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("s4_valids_after", valid_cnt, 4);

    // 5: rst pulse mid-measurement clears everything; resume needs two rises
    restart(10, 3);
    run_wave(10, 3, 3);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("s5_period", 32'(bus.period), 0);
    check("s5_high", 32'(bus.high_time), 0);
    check("s5_valid", 32'(bus.valid), 0);
    check("s5_stalled", 32'(bus.stalled), 0);
    check("s5_valids_before", valid_cnt, 2);
    valid_cnt = 0;
    run_wave(10, 3, 4);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("s5_valids_after", valid_cnt, 3);
    check("s5_period_after", 32'(bus.period), 10);

    // 3: CNT_WIDTH=8, one rise then held low -> stall near 254 clks after load
    bus8.en = 1'b1;
    valid8_cnt = 0;
    @(posedge clk); #1 bus8.sig_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus8.sig_in = 1'b0;
    repeat (252) @(posedge clk);
    @(negedge clk);
    check("s3_not_yet_stalled", 32'(bus8.stalled), 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("s3_stalled", 32'(bus8.stalled), 1);
    check("s3_stall_period", 32'(bus8.period), 0);
    @(posedge clk); #1 bus8.sig_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus8.sig_in = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("s3_stall_cleared", 32'(bus8.stalled), 0);
    check("s3_no_valid", valid8_cnt, 0);
    @(posedge clk); #1 bus8.sig_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus8.sig_in = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("s3_valids", valid8_cnt, 1);
    check("s3_period", 32'(bus8.period), 20);
    check("s3_high", 32'(bus8.high_time), 3);

    // 6: async phase, period 1000 clks, high 400 clks, 50 cycles
    restart(1000, 400);
    off = $urandom_range(1, 4);
    @(posedge clk); #(off);
    for (int i = 0; i < 50; i++) begin
      bus.sig_in = 1'b1;
      #4000;
      bus.sig_in = 1'b0;
      #6000;
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("s6_valids", valid_cnt, 49);
    check("s6_period", 32'(bus.period), 1000);
    check("s6_high", 32'(bus.high_time), 400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
